seq_su_multiplier: RTL
======================

// Module: seq_su_multiplier
// PURPOSE
//   Iterative (shift-add) multiplier: signed or unsigned WIDTH x WIDTH -> 2*WIDTH product.
//   Successor to the fixed combinational 4x4 signed/unsigned multiplier.
//   Adds width parametrisation, a valid/ready handshake and one-bit-per-cycle operation,
//   so wide operands cost no large array. Sits between the tile's input pins and uo_out.
// PARAMETERS
//   WIDTH  4  operand width in bits (2..16); the product is 2*WIDTH bits.
// PORTS
//   clk          in   1        clock; all state changes on the rising edge
//   rst_n        in   1        asynchronous, active-low reset
//   in_valid     in   1        operands and mode are presented
//   in_ready     out  1        block accepts operands this cycle
//   multiplicand in   WIDTH    operand A
//   multiplier   in   WIDTH    operand B
//   signed_mode  in   1        1 = two's-complement operands, 0 = unsigned
//   out_valid    out  1        product is valid
//   out_ready    in   1        consumer takes the product this cycle
//   product      out  2*WIDTH  result
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE; in_ready=1, out_valid=0,
//     product=0, accumulator=0, count=0.
//   - FSM IDLE -> BUSY -> DONE -> IDLE.
//     IDLE: in_ready=1. If in_valid=1 at an edge, latch A, B and signed_mode.
//       Then set acc=0, count=0 and move to BUSY.
//     BUSY: in_ready=0. One partial product per cycle. If B[count]=1, acc += Aext<<count.
//       Aext = A sign-extended to 2*WIDTH when mode=1, zero-extended when mode=0.
//       When count==WIDTH-1 and mode=1, subtract instead of add (MSB weight -2^(WIDTH-1)).
//       Otherwise count increments. After the WIDTH-th step, move to DONE.
//     DONE: out_valid=1, product=acc (registered, stable).
//       Hold until out_ready=1 at an edge, then go to IDLE with out_valid=0.
//       The product register keeps its last value after this.
//   - Latency: operands accepted at edge T; out_valid high after edge T+WIDTH.
//     Minimum initiation interval is WIDTH+2 cycles.
//   - Handshake: in_ready depends only on state (no combinational path from in_valid).
//     out_valid never drops without out_ready. Input pins are ignored outside IDLE.
//     Latched operands are immune to input changes mid-operation.
//   - Arithmetic: the accumulator is 2*WIDTH bits and wraps modulo 2^(2*WIDTH).
//     The exact product always fits, including -2^(W-1) * -2^(W-1) in signed mode.
//   - B=0 or A=0 still takes the full WIDTH cycles (fixed latency, no early exit).
//   - in_valid and out_ready both high in DONE: only the output is consumed.
//     New operands are accepted the next cycle, in IDLE.
//   - Reset asserted mid-BUSY or mid-DONE: the operation is discarded.
//     All outputs return to reset values immediately.
// STRUCTURE
//   - Shared package: state enum (IDLE, BUSY, DONE).
//   - Shared package: localparam PW = 2*WIDTH.
//   - Shared package: function clog2 for the count width.
//   - Sub-module su_mult_step: combinational 2*WIDTH add/subtract of a shifted, extended operand.
//     It is the only natural split; the FSM and registers stay in seq_su_multiplier.
// TESTING
//   1 WIDTH=4, unsigned, A=15 B=15 -> product=0x00E1 valid at T+4; out_valid held until out_ready.
//   2 WIDTH=4, signed, A=-8 (0x8) B=7 -> 0xC8; A=-8 B=-8 -> 0x40; A=-1 B=1 -> 0xFF.
//   3 out_ready low 10 cycles in DONE -> product/out_valid stable, in_ready=0; in_valid ignored.
//   4 Operands changed during BUSY (A 3->9) -> result uses latched A=3: 3*5=0x0F.
//   5 rst_n low at BUSY step 2 -> out_valid=0, in_ready=1 at once; next op 6*7 -> 0x2A.
//   6 WIDTH=8, random 1000 ops in both modes, random back-pressure -> match the reference model.

Source files
------------

// File: rtl/seq_su_multiplier_pkg.sv
// Shared definitions for the iterative signed/unsigned multiplier.
// Holds the FSM state encoding, default widths and a ceil-log2 helper for the step counter.
package seq_su_multiplier_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int PW            = 2 * WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Returns at least 1, so a counter is never zero bits wide.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_su_multiplier_if.sv
// Operand/product handshake bundle for seq_su_multiplier.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface seq_su_multiplier_if
  import seq_su_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, multiplicand, multiplier, signed_mode, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, signed_mode, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/seq_su_multiplier_step.sv
// One shift-add step: acc +/- (extended A << shift) when the current B bit is set.
// Subtraction is used for the signed MSB, whose weight is -2^(WIDTH-1).
module su_mult_step
  import seq_su_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CW    = clog2(WIDTH)
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [CW-1:0]      shift_i,
  input  logic               signed_i,
  input  logic               add_en_i,
  input  logic               sub_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] a_shift;

  assign a_ext   = {{WIDTH{signed_i & a_i[WIDTH-1]}}, a_i};
  assign a_shift = a_ext << shift_i;

  always_comb begin
    acc_o = acc_i;
    if (add_en_i) begin
      acc_o = sub_i ? (acc_i - a_shift) : (acc_i + a_shift);
    end
  end

endmodule

// File: rtl/seq_su_multiplier.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH multiplier, one partial product per cycle.
// Fixed latency of WIDTH cycles from operand acceptance to out_valid; no early exit.
module seq_su_multiplier
  import seq_su_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_su_multiplier_if.slave   bus,
  output mult_state_e          state_o
);

  localparam int            PROD_W = 2 * WIDTH;
  localparam int            CW     = clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

  mult_state_e         state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                mode_q, mode_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PROD_W-1:0]   product_q, product_d;
  logic [PROD_W-1:0]   step_acc;

  su_mult_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .acc_i    (acc_q),
    .a_i      (a_q),
    .shift_i  (count_q),
    .signed_i (mode_q),
    .add_en_i (b_q[count_q]),
    .sub_i    (mode_q && (count_q == LAST)),
    .acc_o    (step_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.multiplicand;
          b_d     = bus.multiplier;
          mode_d  = bus.signed_mode;
          acc_d   = '0;
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = step_acc;
        if (count_q == LAST) begin
          // Product register only changes here, so it stays stable through DONE and after.
          product_d = step_acc;
          count_d   = '0;
          state_d   = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are pure functions of registered state.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = product_q;
  assign state_o       = state_q;

endmodule
